// File: rtl/io_pkg.sv
// Shared definitions for the memory-mapped input port: register map and data width.
package io_pkg;

  localparam int unsigned DATA_W = 16;

  // Read-only register addresses seen by the CPU load path.
  typedef enum logic [1:0] {
    ADDR_SW   = 2'd0,
    ADDR_BTN  = 2'd1,
    ADDR_EVT  = 2'd2,
    ADDR_STAT = 2'd3
  } addr_e;

endpackage

// File: rtl/debounce_bit.sv
// One input bit: two-flop synchronizer, optional polarity inversion after the
// synchronizer, then a stability counter that only accepts a new level once it
// has been seen continuously for DEBOUNCE_CYCLES cycles.
module debounce_bit #(
  parameter int unsigned DEBOUNCE_CYCLES = 500000,
  parameter bit          INVERT          = 1'b0
) (
  input  logic clock,
  input  logic reset,
  input  logic raw,
  output logic stable
);

  localparam int unsigned  CW   = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic          r_sync1;
  logic          r_sync2;
  logic [CW-1:0] r_cnt;
  logic          r_stable;
  logic          w_synced;

  assign w_synced = r_sync2 ^ INVERT;
  assign stable   = r_stable;

  // Synchronize the pin and qualify level changes; any return to the stable
  // level restarts the count, so short glitches are never accepted.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_sync1  <= 1'b0;
      r_sync2  <= 1'b0;
      r_cnt    <= '0;
      r_stable <= 1'b0;
    end else begin
      r_sync1 <= raw;
      r_sync2 <= r_sync1;
      if (w_synced == r_stable) begin
        r_cnt <= '0;
      end else if (r_cnt == LAST) begin
        r_stable <= w_synced;
        r_cnt    <= '0;
      end else begin
        r_cnt <= r_cnt + CW'(1);
      end
    end
  end

endmodule

// File: rtl/input_port_ctrl.sv
// Board button/switch input port: debounced levels, sticky press-event flags
// with clear-on-read, an interrupt line, and a registered read-only register port.
module input_port_ctrl
  import io_pkg::*;
#(
  parameter int unsigned NUM_BTN         = 4,
  parameter int unsigned NUM_SW          = 10,
  parameter int unsigned DEBOUNCE_CYCLES = 500000,
  parameter bit          BTN_ACTIVE_LOW  = 1'b1
) (
  input  logic               clock,
  input  logic               reset,
  input  logic [NUM_BTN-1:0] raw_btn,
  input  logic [NUM_SW-1:0]  raw_sw,
  input  logic               rd_en,
  input  logic [1:0]         rd_addr,
  output logic [DATA_W-1:0]  rd_data,
  output logic               rd_valid,
  output logic               irq
);

  logic [NUM_BTN-1:0] w_btn_stable;
  logic [NUM_SW-1:0]  w_sw_stable;
  logic [NUM_BTN-1:0] r_btn_prev;
  logic [NUM_BTN-1:0] w_btn_rise;
  logic [NUM_BTN-1:0] r_evt;
  logic [NUM_BTN-1:0] w_evt_clr;
  logic [NUM_BTN-1:0] w_evt_next;
  logic [DATA_W-1:0]  w_rd_mux;
  logic [DATA_W-1:0]  r_rd_data;
  logic               r_rd_valid;
  logic               r_irq;

  assign rd_data  = r_rd_data;
  assign rd_valid = r_rd_valid;
  assign irq      = r_irq;

  for (genvar i = 0; i < NUM_BTN; i++) begin : g_btn
    debounce_bit #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
      .INVERT         (BTN_ACTIVE_LOW)
    ) u_db (
      .clock (clock),
      .reset (reset),
      .raw   (raw_btn[i]),
      .stable(w_btn_stable[i])
    );
  end

  for (genvar i = 0; i < NUM_SW; i++) begin : g_sw
    debounce_bit #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
      .INVERT         (1'b0)
    ) u_db (
      .clock (clock),
      .reset (reset),
      .raw   (raw_sw[i]),
      .stable(w_sw_stable[i])
    );
  end

  // Press detection and flag update; a new press in the same cycle as a
  // clearing read keeps its flag because the set term is OR-ed in last.
  always_comb begin
    w_btn_rise = w_btn_stable & ~r_btn_prev;
    w_evt_clr  = '0;
    if (rd_en && (addr_e'(rd_addr) == ADDR_EVT)) begin
      w_evt_clr = r_evt;
    end
    w_evt_next = (r_evt & ~w_evt_clr) | w_btn_rise;
  end

  // Register-map read multiplexer; unused high bits stay zero.
  always_comb begin
    w_rd_mux = '0;
    case (addr_e'(rd_addr))
      ADDR_SW:   w_rd_mux[NUM_SW-1:0]  = w_sw_stable;
      ADDR_BTN:  w_rd_mux[NUM_BTN-1:0] = w_btn_stable;
      ADDR_EVT:  w_rd_mux[NUM_BTN-1:0] = r_evt;
      ADDR_STAT: begin
        w_rd_mux[0] = r_irq;
        w_rd_mux[1] = |w_btn_stable;
      end
    endcase
  end

  // Edge history, sticky flags and interrupt (irq lags the flags by one cycle).
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_btn_prev <= '0;
      r_evt      <= '0;
      r_irq      <= 1'b0;
    end else begin
      r_btn_prev <= w_btn_stable;
      r_evt      <= w_evt_next;
      r_irq      <= |r_evt;
    end
  end

  // Registered read port: data updates only on a read, valid pulses one cycle.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_rd_data  <= '0;
      r_rd_valid <= 1'b0;
    end else begin
      r_rd_valid <= rd_en;
      if (rd_en) begin
        r_rd_data <= w_rd_mux;
      end
    end
  end

endmodule
